// File: rtl/sram_march_bist.sv
// March C- built-in self-test initiator for a single-port sram22 macro.
//
// Drives the macro's synchronous port with one operation per RUN cycle and
// checks the registered read data one cycle later. It records the first
// miscompare and keeps a saturating count of all miscompares.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   start           one-cycle pulse; begins a test when not busy
//   bg_pattern      data background, sampled at start
//   busy, done      test in progress / test complete (sticky)
//   fail            at least one miscompare (sticky)
//   fail_count      saturating miscompare count
//   fail_addr/elem/expected/actual   details of the first miscompare
//   sram_we/wmask/addr/din           registered SRAM request port
//   sram_dout       SRAM read data, valid the cycle after a read
module sram_march_bist #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WMASK_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  bg_pattern,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [7:0]             fail_count,
  output logic [ADDR_WIDTH-1:0]  fail_addr,
  output logic [2:0]             fail_elem,
  output logic [DATA_WIDTH-1:0]  fail_expected,
  output logic [DATA_WIDTH-1:0]  fail_actual,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [ADDR_WIDTH-1:0] AddrLast = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2:0]            ElemLast = 3'd5;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   bg_q, bg_d;

  // Sequencer: describes the operation currently presented on the SRAM port.
  logic [2:0]              elem_q, elem_d;
  logic [ADDR_WIDTH-1:0]   seq_addr_q, seq_addr_d;
  logic                    phase_q, phase_d;  // 0: read slot, 1: write slot

  logic                    we_d;
  logic [WMASK_WIDTH-1:0]  wmask_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   din_d;

  // Compare pipeline: read presented in cycle N is checked in cycle N+1.
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_exp_q, rd_exp_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic [2:0]              rd_elem_q;

  logic                    fail_d;
  logic [7:0]              fail_count_d;
  logic [ADDR_WIDTH-1:0]   fail_addr_d;
  logic [2:0]              fail_elem_d;
  logic [DATA_WIDTH-1:0]   fail_expected_d, fail_actual_d;

  logic                    two_op, down, clear_res, miscompare;
  logic [ADDR_WIDTH-1:0]   last_addr;
  logic [2:0]              nx_elem;
  logic [ADDR_WIDTH-1:0]   nx_addr;
  logic                    nx_phase;
  logic                    op_en, op_write, op_one;
  logic [2:0]              op_elem;
  logic [ADDR_WIDTH-1:0]   op_addr;
  logic                    op_phase;
  logic [DATA_WIDTH-1:0]   op_bg;

  // Next operation in the March C- order, derived from the current one.
  always_comb begin
    two_op    = (elem_q >= 3'd1) && (elem_q <= 3'd4);
    down      = (elem_q == 3'd3) || (elem_q == 3'd4);
    last_addr = down ? '0 : AddrLast;
    nx_elem   = elem_q;
    nx_addr   = seq_addr_q;
    nx_phase  = 1'b0;
    if (two_op && !phase_q) begin
      nx_phase = 1'b1;
    end else if (seq_addr_q != last_addr) begin
      nx_addr = down ? (seq_addr_q - AddrOne) : (seq_addr_q + AddrOne);
    end else begin
      nx_elem = elem_q + 3'd1;
      nx_addr = ((nx_elem == 3'd3) || (nx_elem == 3'd4)) ? AddrLast : '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    bg_d      = bg_q;
    clear_res = 1'b0;
    op_en     = 1'b0;
    op_elem   = nx_elem;
    op_addr   = nx_addr;
    op_phase  = nx_phase;
    op_bg     = bg_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StRun;
          bg_d      = bg_pattern;
          clear_res = 1'b1;
          op_en     = 1'b1;
          op_elem   = 3'd0;
          op_addr   = '0;
          op_phase  = 1'b0;
          op_bg     = bg_pattern;
        end
      end
      StRun: begin
        if (elem_q == ElemLast && seq_addr_q == AddrLast) begin
          state_d = StDrain;
        end else begin
          op_en = 1'b1;
        end
      end
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase

    elem_d     = op_en ? op_elem : elem_q;
    seq_addr_d = op_en ? op_addr : seq_addr_q;
    phase_d    = op_en ? op_phase : phase_q;

    // e0 is write-only, e5 read-only; e1..e4 write in their second slot.
    op_write = (op_elem == 3'd0) ||
               ((op_elem >= 3'd1) && (op_elem <= 3'd4) && op_phase);
    // Elements e1 and e3 write the inverted background.
    op_one   = (op_elem == 3'd1) || (op_elem == 3'd3);
    we_d     = op_en && op_write;
    wmask_d  = {WMASK_WIDTH{we_d}};
    addr_d   = op_en ? op_addr : '0;
    din_d    = we_d ? (op_one ? ~op_bg : op_bg) : '0;

    // Capture the read now on the port; e2 and e4 expect the inverted background.
    rd_valid_d = (state_q == StRun) && !sram_we;
    rd_exp_d   = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~bg_q : bg_q;
  end

  // Case inequality so an X on the read data counts as a miscompare.
  assign miscompare = rd_valid_q && (sram_dout !== rd_exp_q);

  always_comb begin
    fail_d          = fail;
    fail_count_d    = fail_count;
    fail_addr_d     = fail_addr;
    fail_elem_d     = fail_elem;
    fail_expected_d = fail_expected;
    fail_actual_d   = fail_actual;
    if (clear_res) begin
      fail_d          = 1'b0;
      fail_count_d    = '0;
      fail_addr_d     = '0;
      fail_elem_d     = '0;
      fail_expected_d = '0;
      fail_actual_d   = '0;
    end else if (miscompare) begin
      fail_d = 1'b1;
      if (fail_count != 8'hFF) begin
        fail_count_d = fail_count + 8'd1;
      end
      if (!fail) begin
        fail_addr_d     = rd_addr_q;
        fail_elem_d     = rd_elem_q;
        fail_expected_d = rd_exp_q;
        fail_actual_d   = sram_dout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      bg_q          <= '0;
      elem_q        <= '0;
      seq_addr_q    <= '0;
      phase_q       <= 1'b0;
      sram_we       <= 1'b0;
      sram_wmask    <= '0;
      sram_addr     <= '0;
      sram_din      <= '0;
      rd_valid_q    <= 1'b0;
      rd_exp_q      <= '0;
      rd_addr_q     <= '0;
      rd_elem_q     <= '0;
      fail          <= 1'b0;
      fail_count    <= '0;
      fail_addr     <= '0;
      fail_elem     <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else begin
      state_q       <= state_d;
      bg_q          <= bg_d;
      elem_q        <= elem_d;
      seq_addr_q    <= seq_addr_d;
      phase_q       <= phase_d;
      sram_we       <= we_d;
      sram_wmask    <= wmask_d;
      sram_addr     <= addr_d;
      sram_din      <= din_d;
      rd_valid_q    <= rd_valid_d;
      rd_exp_q      <= rd_exp_d;
      rd_addr_q     <= sram_addr;
      rd_elem_q     <= elem_q;
      fail          <= fail_d;
      fail_count    <= fail_count_d;
      fail_addr     <= fail_addr_d;
      fail_elem     <= fail_elem_d;
      fail_expected <= fail_expected_d;
      fail_actual   <= fail_actual_d;
    end
  end

  assign busy = (state_q == StRun) || (state_q == StDrain);
  assign done = (state_q == StDone);

endmodule
